router_fsm_np: RTL and testbench

Parametrised control FSM for the packet router. It sits between the register block and the per-port output FIFOs and generalises the three-port controller to NUM_PORTS destinations. It also adds two behaviours the three-port controller lacks: headers addressed to a non-existent port are dropped, and a bounded WAIT_TILL_EMPTY timeout discards a packet whose destination FIFO never drains.

---
 rtl/router_fsm_np.sv | 140 ++++++++++++++
 tb/tb_router_fsm_np.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_np.sv
// rtl/router_fsm_np.sv - parametrised packet router control FSM
// Adds invalid-address drop and a bounded wait for the destination FIFO to drain.
module router_fsm_np #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 drop_state,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    addr_q,
  output logic                 timeout_err
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    LOAD_PARITY        = 4'd4,
    FIFO_FULL_STATE    = 4'd5,
    LOAD_AFTER_FULL    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  localparam bit          TIMEOUT_EN = (WAIT_TIMEOUT != 0);
  localparam logic [15:0] WAIT_LAST  = 16'(WAIT_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        timeout_hit;
  logic        addr_ok, empty_in, empty_q, sreset_q;

  // Port selects are decoded by compare so an out-of-range address never indexes past the vectors.
  always_comb begin
    addr_ok  = 1'b0;
    empty_in = 1'b0;
    empty_q  = 1'b0;
    sreset_q = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_in == ADDR_W'(i)) begin
        addr_ok  = 1'b1;
        empty_in = fifo_empty[i];
      end
      if (addr_q == ADDR_W'(i)) begin
        empty_q  = fifo_empty[i];
        sreset_q = soft_reset[i];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (!addr_ok)      state_nxt = DROP_PACKET;
          else if (empty_in) state_nxt = LOAD_FIRST_DATA;
          else               state_nxt = WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_q) begin
          state_nxt = LOAD_FIRST_DATA;
        end else if (TIMEOUT_EN && wait_cnt == WAIT_LAST) begin
          state_nxt   = DROP_PACKET;
          timeout_hit = 1'b1;
        end
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_nxt = FIFO_FULL_STATE;
        else if (!pkt_valid) state_nxt = LOAD_PARITY;
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_nxt = DECODE_ADDRESS;
        else if (low_pkt_valid) state_nxt = LOAD_PARITY;
        else                    state_nxt = LOAD_DATA;
      end
      DROP_PACKET: begin
        if (!pkt_valid) state_nxt = DECODE_ADDRESS;
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase
    // A soft reset on the latched port aborts the packet and suppresses any timeout report.
    if (sreset_q && state != DECODE_ADDRESS && state != DROP_PACKET) begin
      state_nxt   = DECODE_ADDRESS;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= DECODE_ADDRESS;
      addr_q      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS) addr_q <= data_in;
      wait_cnt    <= (state == WAIT_TILL_EMPTY && state_nxt == WAIT_TILL_EMPTY) ? wait_cnt + 16'd1 : '0;
      timeout_err <= timeout_hit;
    end
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign drop_state    = (state == DROP_PACKET);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
  assign busy          = (state == WAIT_TILL_EMPTY) || (state == LOAD_FIRST_DATA) ||
                         (state == LOAD_PARITY) || (state == FIFO_FULL_STATE) ||
                         (state == LOAD_AFTER_FULL) || (state == CHECK_PARITY_ERROR);

endmodule

// File: tb/tb_router_fsm_np.sv
// tb/tb_router_fsm_np.sv - bench for router_fsm_np (5 ports, 3-bit address, wait limit 4)
module tb_router_fsm_np;
  localparam int NP = 5;
  localparam int AW = 3;
  localparam int TO = 4;

  localparam int S_D = 0, S_W = 1, S_LFD = 2, S_LD = 3, S_LP = 4;
  localparam int S_FFS = 5, S_LAF = 6, S_CPE = 7, S_DROP = 8;

  logic          clock = 1'b0;
  logic          resetn, pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [AW-1:0] data_in;
  logic [NP-1:0] fifo_empty, soft_reset;
  logic          detect_add, lfd_state, ld_state, laf_state, full_state;
  logic          rst_int_reg, drop_state, write_enb_reg, busy, timeout_err;
  logic [AW-1:0] addr_q;

  int            total = 0;
  int            bad = 0;
  int            m_state = S_D;
  int            m_cnt = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_terr = 1'b0;

  always #5 clock = ~clock;

  router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .drop_state(drop_state),
    .write_enb_reg(write_enb_reg), .busy(busy), .addr_q(addr_q), .timeout_err(timeout_err)
  );

  // Reference: one clock of the packet router's behaviour, straight from its transition rules.
  function automatic void model_update();
    int  nxt;
    bit  fire;
    nxt  = m_state;
    fire = 0;
    if (!resetn) begin
      m_state = S_D; m_addr = '0; m_cnt = 0; m_terr = 1'b0;
      return;
    end
    case (m_state)
      S_D:    if (pkt_valid) nxt = (data_in >= NP) ? S_DROP : (fifo_empty[data_in] ? S_LFD : S_W);
      S_W:    if (fifo_empty[m_addr]) nxt = S_LFD;
              else if (m_cnt == TO - 1) begin nxt = S_DROP; fire = 1; end
      S_LFD:  nxt = S_LD;
      S_LD:   nxt = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
      S_LP:   nxt = S_CPE;
      S_CPE:  nxt = fifo_full ? S_FFS : S_D;
      S_FFS:  nxt = fifo_full ? S_FFS : S_LAF;
      S_LAF:  nxt = parity_done ? S_D : (low_pkt_valid ? S_LP : S_LD);
      default: nxt = pkt_valid ? S_DROP : S_D;
    endcase
    if (m_state != S_D && m_state != S_DROP && soft_reset[m_addr]) begin
      nxt = S_D; fire = 0;
    end
    m_terr = fire;
    m_cnt  = (m_state == S_W && nxt == S_W) ? m_cnt + 1 : 0;
    if (m_state == S_D) m_addr = data_in;
    m_state = nxt;
  endfunction

  // {detect,lfd,ld,laf,full,rst_int,drop, write_enb, busy, addr_q, timeout_err}
  function automatic logic [12:0] exp_vec();
    logic [8:0] d;
    case (m_state)
      S_D:     d = 9'b1000000_00;
      S_W:     d = 9'b0000000_01;
      S_LFD:   d = 9'b0100000_01;
      S_LD:    d = 9'b0010000_10;
      S_LP:    d = 9'b0000000_11;
      S_FFS:   d = 9'b0000100_01;
      S_LAF:   d = 9'b0001000_11;
      S_CPE:   d = 9'b0000010_01;
      default: d = 9'b0000001_00;
    endcase
    return {d, m_addr, m_terr};
  endfunction

  function automatic logic [12:0] obs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state,
            write_enb_reg, busy, addr_q, timeout_err};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    resetn = 1'b1; pkt_valid = 1'b0; data_in = '0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0; fifo_empty = '1; soft_reset = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    data_in = 3'd6;
    tick(); tick();
    total++;
    if (obs() !== 13'b1000000_00_000_0) begin
      bad++; $display("FAIL reset_state: got %b want %b", obs(), 13'b1000000_00_000_0);
    end
    resetn = 1'b1;
    data_in = '0;
    tick();
    total++;
    if (obs() !== exp_vec()) begin bad++; $display("FAIL reset_release: got %b want %b", obs(), exp_vec()); end
  endtask

  task automatic test_packet();
    int we_n, busy_n;
    we_n = 0; busy_n = 0;
    idle_inputs();
    tick();
    pkt_valid = 1'b1; data_in = 3'd2;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) pkt_valid = 1'b0;
      tick();
      we_n += int'(write_enb_reg);
      busy_n += int'(busy);
      total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL packet cyc%0d: got %b want %b", i, obs(), exp_vec()); end
    end
    total++;
    if (we_n !== 4 || busy_n !== 3) begin
      bad++; $display("FAIL packet_counts: got we=%0d busy=%0d want we=4 busy=3", we_n, busy_n);
    end
  endtask

  task automatic test_drop();
    int drop_n, act_n;
    drop_n = 0; act_n = 0;
    idle_inputs();
    tick();
    pkt_valid = 1'b1; data_in = 3'd5;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) pkt_valid = 1'b0;
      if (i >= 1) data_in = AW'($urandom_range(0, 7));
      tick();
      drop_n += int'(drop_state);
      act_n += int'(write_enb_reg) + int'(busy);
      total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL drop cyc%0d: got %b want %b", i, obs(), exp_vec()); end
    end
    total++;
    if (drop_n !== 5 || act_n !== 0 || detect_add !== 1'b1) begin
      bad++; $display("FAIL drop_counts: got drop=%0d we+busy=%0d detect=%b want 5 0 1", drop_n, act_n, detect_add);
    end
  endtask

  task automatic test_timeout();
    int wait_n, err_n;
    wait_n = 0; err_n = 0;
    idle_inputs();
    fifo_empty = 5'b11101;
    tick();
    pkt_valid = 1'b1; data_in = 3'd1;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) pkt_valid = 1'b0;
      tick();
      wait_n += int'(busy && !lfd_state && !ld_state && !laf_state && !full_state && !rst_int_reg && !write_enb_reg);
      err_n += int'(timeout_err);
      total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL timeout cyc%0d: got %b want %b", i, obs(), exp_vec()); end
    end
    total++;
    if (wait_n !== TO || err_n !== 1 || detect_add !== 1'b1 || addr_q !== 3'd1) begin
      bad++; $display("FAIL timeout_counts: got wait=%0d err=%0d detect=%b addr=%0d want 4 1 1 1", wait_n, err_n, detect_add, addr_q);
    end
  endtask

  task automatic test_timeout_race();
    int err_n;
    err_n = 0;
    idle_inputs();
    fifo_empty = 5'b11101;
    tick();
    pkt_valid = 1'b1; data_in = 3'd1;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) fifo_empty = 5'b11111;
      if (i == 5) pkt_valid = 1'b0;
      tick();
      err_n += int'(timeout_err);
      total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL race cyc%0d: got %b want %b", i, obs(), exp_vec()); end
      if (i == 4) begin
        total++;
        if (lfd_state !== 1'b1) begin bad++; $display("FAIL race_lfd: got lfd=%b want 1", lfd_state); end
      end
    end
    total++;
    if (err_n !== 0) begin bad++; $display("FAIL race_err: got %0d pulses want 0", err_n); end
  endtask

  task automatic test_full_soft();
    int full_n;
    full_n = 0;
    idle_inputs();
    tick();
    pkt_valid = 1'b1; data_in = 3'd4;
    tick(); tick();
    total++;
    if (ld_state !== 1'b1) begin bad++; $display("FAIL full_enter_ld: got ld=%b want 1", ld_state); end
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      full_n += int'(full_state);
    end
    total++;
    if (full_n !== 3) begin bad++; $display("FAIL full_ffs_count: got %0d want 3", full_n); end
    fifo_full = 1'b0;
    tick();
    total++;
    if (laf_state !== 1'b1) begin bad++; $display("FAIL full_laf: got laf=%b want 1", laf_state); end
    tick();
    total++;
    if (ld_state !== 1'b1) begin bad++; $display("FAIL full_back_ld: got ld=%b want 1", ld_state); end
    soft_reset = 5'b00001;
    tick();
    total++;
    if (obs() !== exp_vec() || ld_state !== 1'b1) begin
      bad++; $display("FAIL soft_other_port: got %b want %b", obs(), exp_vec());
    end
    soft_reset = '0; fifo_full = 1'b1;
    tick();
    soft_reset = 5'b10000; pkt_valid = 1'b0;
    tick();
    total++;
    if (obs() !== exp_vec() || detect_add !== 1'b1) begin
      bad++; $display("FAIL soft_own_port: got %b want %b", obs(), exp_vec());
    end
    soft_reset = '0; fifo_full = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    tick();
    pkt_valid = 1'b1; data_in = 3'd3;
    tick(); tick();
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    tick();
    total++;
    if (laf_state !== 1'b1 || addr_q !== 3'd3) begin
      bad++; $display("FAIL midreset_setup: got laf=%b addr=%0d want 1 3", laf_state, addr_q);
    end
    resetn = 1'b0;
    tick();
    total++;
    if (detect_add !== 1'b1 || addr_q !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset: got detect=%b addr=%0d busy=%b want 1 0 0", detect_add, addr_q, busy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 4000; i++) begin
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) pkt_valid = ~pkt_valid;
      data_in = AW'($urandom_range(0, 7));
      for (int b = 0; b < NP; b++) begin
        fifo_empty[b] = ($urandom_range(0, 9) < 3);
        soft_reset[b] = ($urandom_range(0, 79) == 0);
      end
      fifo_full = ($urandom_range(0, 9) < 2);
      parity_done = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 4) == 0);
      tick();
      total++;
      if (obs() !== exp_vec()) begin bad++; $display("FAIL random cyc%0d: got %b want %b", i, obs(), exp_vec()); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_packet();
    test_drop();
    test_timeout();
    test_timeout_race();
    test_full_soft();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
